// File: rtl/alu_acc_sequencer.sv
// rtl/alu_acc_sequencer.sv - accumulator sequencer that feeds a fixed-latency ALU
//
// Purpose:
//   Accepts one instruction (opcode + operand) at a time. It drives the ALU with
//   the accumulator on io_alu_a and the latched operand/opcode on io_alu_b/io_alu_op.
//   After ALU_LAT cycles it writes io_alu_result back into the accumulator.
//   The block does no arithmetic of its own.
//
// Ports:
//   clock, reset          rising-edge clock; synchronous active-low reset
//   io_clear              synchronous abort: zero accumulator, drop in-flight op
//   io_in_valid/ready     instruction handshake; io_in_op / io_in_operand payload
//   io_alu_a/b/op         to ALU (accumulator, latched operand, latched opcode)
//   io_alu_result         from ALU
//   io_acc                accumulator value
//   io_out_valid          one-cycle pulse after each retire (write-back)
//   io_busy               instruction in flight
//   io_op_count           retired-instruction counter (wraps at 16 bits)
module alu_acc_sequencer #(
  parameter int WIDTH   = 16,
  parameter int ALU_LAT = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_clear,
  input  logic             io_in_valid,
  output logic             io_in_ready,
  input  logic [2:0]       io_in_op,
  input  logic [WIDTH-1:0] io_in_operand,
  output logic [WIDTH-1:0] io_alu_a,
  output logic [WIDTH-1:0] io_alu_b,
  output logic [2:0]       io_alu_op,
  input  logic [WIDTH-1:0] io_alu_result,
  output logic [WIDTH-1:0] io_acc,
  output logic             io_out_valid,
  output logic             io_busy,
  output logic [15:0]      io_op_count
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_EXEC = 1'b1;
  localparam logic [2:0] LAT     = 3'(ALU_LAT);

  logic [0:0]       state_q,     state_d;
  logic [WIDTH-1:0] acc_q,       acc_d;
  logic [WIDTH-1:0] operand_q,   operand_d;
  logic [2:0]       op_q,        op_d;
  logic [2:0]       cnt_q,       cnt_d;
  logic [15:0]      op_count_q,  op_count_d;
  logic             out_valid_q, out_valid_d;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    operand_d   = operand_q;
    op_d        = op_q;
    cnt_d       = cnt_q;
    op_count_d  = op_count_q;
    out_valid_d = 1'b0;

    // Clear beats any handshake or retire in the same cycle; the retire count is kept.
    if (io_clear) begin
      state_d = ST_IDLE;
      acc_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (io_in_valid) begin
            op_d      = io_in_op;
            operand_d = io_in_operand;
            cnt_d     = '0;
            state_d   = ST_EXEC;
          end
        end
        default: begin
          // The counter marks how long the ALU inputs have been stable. The result
          // is taken at the edge where the counter has reached the ALU latency.
          if (cnt_q == LAT) begin
            acc_d       = io_alu_result;
            op_count_d  = op_count_q + 16'd1;
            out_valid_d = 1'b1;
            state_d     = ST_IDLE;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      operand_q   <= '0;
      op_q        <= '0;
      cnt_q       <= '0;
      op_count_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      operand_q   <= operand_d;
      op_q        <= op_d;
      cnt_q       <= cnt_d;
      op_count_q  <= op_count_d;
      out_valid_q <= out_valid_d;
    end
  end

  // io_alu_a comes from the registered accumulator, never from io_alu_result, so
  // there is no combinational loop through the ALU.
  assign io_alu_a     = acc_q;
  assign io_alu_b     = operand_q;
  assign io_alu_op    = op_q;
  assign io_acc       = acc_q;
  assign io_out_valid = out_valid_q;
  assign io_in_ready  = (state_q == ST_IDLE);
  assign io_busy      = (state_q == ST_EXEC);
  assign io_op_count  = op_count_q;

endmodule
